// File: rtl/sprite_motion_ctrl_pkg.sv
// rtl/sprite_motion_ctrl_pkg.sv - shared screen constants, coordinate types and edge-folding helpers (wrap helper built only with SPRITE_MOTION_WRAP_EN)
package sprite_pkg;

   localparam int H_RES        = 640;
   localparam int V_RES        = 480;
   localparam int SCREEN_CORDW = 16;
   localparam int STEP_W       = 5;

   typedef logic [SCREEN_CORDW-1:0]      coord_t;
   typedef logic signed [STEP_W-1:0]     step_t;
   typedef logic signed [SCREEN_CORDW:0] wide_t;

   typedef struct packed {
      coord_t pos;
      logic   hit;
   } axis_res_t;

   // Saturate a signed candidate position into 0..max_pos, flagging any correction.
   function automatic axis_res_t clamp_axis(input wide_t sum, input coord_t max_pos);
      axis_res_t r;
      wide_t     lim;
      lim   = wide_t'({1'b0, max_pos});
      r.pos = sum[SCREEN_CORDW-1:0];
      r.hit = 1'b0;
      if (sum < 0) begin
         r.pos = '0;
         r.hit = 1'b1;
      end else if (sum > lim) begin
         r.pos = max_pos;
         r.hit = 1'b1;
      end
      return r;
   endfunction

`ifdef SPRITE_MOTION_WRAP_EN
   // Fold a signed candidate position back onto the 0..max_pos ring; one fold
   // suffices because a step is always far smaller than the playfield.
   function automatic axis_res_t wrap_axis(input wide_t sum, input coord_t max_pos);
      axis_res_t r;
      wide_t     span;
      span  = wide_t'({1'b0, max_pos}) + wide_t'(1);
      r.pos = sum[SCREEN_CORDW-1:0];
      r.hit = 1'b0;
      if (sum < 0) begin
         r.pos = coord_t'(sum + span);
         r.hit = 1'b1;
      end else if (sum >= span) begin
         r.pos = coord_t'(sum - span);
         r.hit = 1'b1;
      end
      return r;
   endfunction
`endif

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// rtl/sprite_motion_ctrl_if.sv - per-object move command and position bus
interface sprite_motion_ctrl_if #(
   parameter int N_OBJ  = 4,
   parameter int STEP_W = 5
);
   import sprite_pkg::*;

   logic [N_OBJ-1:0]              move_valid;
   logic [N_OBJ-1:0]              move_ready;
   logic [N_OBJ-1:0][STEP_W-1:0]  move_dx;
   logic [N_OBJ-1:0][STEP_W-1:0]  move_dy;
   logic [N_OBJ-1:0]              wrap_mode;
   coord_t [N_OBJ-1:0]            obj_x;
   coord_t [N_OBJ-1:0]            obj_y;
   logic [N_OBJ-1:0]              edge_hit;

   modport master (
      output move_valid, move_dx, move_dy, wrap_mode,
      input  move_ready, obj_x, obj_y, edge_hit
   );

   modport slave (
      input  move_valid, move_dx, move_dy, wrap_mode,
      output move_ready, obj_x, obj_y, edge_hit
   );

endinterface

// File: rtl/sprite_motion_ctrl_channel.sv
// rtl/sprite_motion_ctrl_channel.sv - one object: pending slot, position adder, clamp/wrap (wrap only with SPRITE_MOTION_WRAP_EN)
module motion_channel
   import sprite_pkg::*;
#(
   parameter int     STEP_W = 5,
   parameter coord_t INIT_X = '0,
   parameter coord_t INIT_Y = '0,
   parameter coord_t X_MAX  = '0,
   parameter coord_t Y_MAX  = '0
) (
   input  logic                     clk_pix,
   input  logic                     rst_n,
   input  logic                     frame_i,
   input  logic                     move_valid_i,
   input  logic signed [STEP_W-1:0] move_dx_i,
   input  logic signed [STEP_W-1:0] move_dy_i,
   input  logic                     wrap_mode_i,
   output logic                     move_ready_o,
   output coord_t                   obj_x_o,
   output coord_t                   obj_y_o,
   output logic                     edge_hit_o
);

   logic                     pend_valid_q, pend_valid_d;
   logic signed [STEP_W-1:0] pend_dx_q, pend_dx_d;
   logic signed [STEP_W-1:0] pend_dy_q, pend_dy_d;
   logic                     ready_q, ready_d;
   coord_t                   x_q, x_d;
   coord_t                   y_q, y_d;
   logic                     edge_q, edge_d;

   logic      accept;
   wide_t     sum_x, sum_y;
   axis_res_t res_x, res_y;

   // The slot reopens during the frame cycle itself, so a command may land
   // in the same cycle the previous one is being committed.
   assign move_ready_o = ready_q | frame_i;
   assign accept       = move_valid_i & move_ready_o;

   assign sum_x = wide_t'({1'b0, x_q}) + wide_t'(pend_dx_q);
   assign sum_y = wide_t'({1'b0, y_q}) + wide_t'(pend_dy_q);

`ifdef SPRITE_MOTION_WRAP_EN
   // Edge handling per object, selected by wrap_mode as seen in the frame cycle.
   always_comb begin
      res_x = clamp_axis(sum_x, X_MAX);
      res_y = clamp_axis(sum_y, Y_MAX);
      if (wrap_mode_i) begin
         res_x = wrap_axis(sum_x, X_MAX);
         res_y = wrap_axis(sum_y, Y_MAX);
      end
   end
`else
   logic unused_wrap;
   assign unused_wrap = wrap_mode_i;

   // Edge handling: every object clamps.
   always_comb begin
      res_x = clamp_axis(sum_x, X_MAX);
      res_y = clamp_axis(sum_y, Y_MAX);
   end
`endif

   // Next state: commit the pending step on frame, then refill or free the slot.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_dx_d    = pend_dx_q;
      pend_dy_d    = pend_dy_q;
      ready_d      = ready_q;
      x_d          = x_q;
      y_d          = y_q;
      edge_d       = 1'b0;
      if (frame_i && pend_valid_q) begin
         x_d    = res_x.pos;
         y_d    = res_y.pos;
         edge_d = res_x.hit | res_y.hit;
      end
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_dx_d    = move_dx_i;
         pend_dy_d    = move_dy_i;
         ready_d      = 1'b0;
      end else if (frame_i) begin
         pend_valid_d = 1'b0;
         ready_d      = 1'b1;
      end
   end

   // State registers; reset drops any pending command and restores the home position.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_q <= 1'b0;
         pend_dx_q    <= '0;
         pend_dy_q    <= '0;
         ready_q      <= 1'b1;
         x_q          <= INIT_X;
         y_q          <= INIT_Y;
         edge_q       <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_dx_q    <= pend_dx_d;
         pend_dy_q    <= pend_dy_d;
         ready_q      <= ready_d;
         x_q          <= x_d;
         y_q          <= y_d;
         edge_q       <= edge_d;
      end
   end

   assign obj_x_o    = x_q;
   assign obj_y_o    = y_q;
   assign edge_hit_o = edge_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - frame-synchronous motion controller for N_OBJ sprites (wrap option: SPRITE_MOTION_WRAP_EN)
module sprite_motion_ctrl
   import sprite_pkg::*;
#(
   parameter int N_OBJ  = 4,
   parameter int OBJ_W  = 68,
   parameter int OBJ_H  = 72,
   parameter int STEP_W = 5,
   parameter int INIT_Y = 300
) (
   input  logic                 clk_pix,
   input  logic                 rst_n,
   input  logic                 frame,
   output logic                 commit,
   sprite_motion_ctrl_if.slave  bus
);

   localparam int X_MAX = H_RES - OBJ_W;
   localparam int Y_MAX = V_RES - OBJ_H;

   // Home x spreads objects evenly across the screen, never past the right edge.
   function automatic coord_t home_x(input int idx);
      int v;
      v = idx * (H_RES / N_OBJ);
      if (v > X_MAX) v = X_MAX;
      return coord_t'(v);
   endfunction

   logic commit_q;

   for (genvar g = 0; g < N_OBJ; g++) begin : g_ch
      motion_channel #(
         .STEP_W (STEP_W),
         .INIT_X (home_x(g)),
         .INIT_Y (coord_t'(INIT_Y)),
         .X_MAX  (coord_t'(X_MAX)),
         .Y_MAX  (coord_t'(Y_MAX))
      ) u_ch (
         .clk_pix      (clk_pix),
         .rst_n        (rst_n),
         .frame_i      (frame),
         .move_valid_i (bus.move_valid[g]),
         .move_dx_i    (bus.move_dx[g]),
         .move_dy_i    (bus.move_dy[g]),
         .wrap_mode_i  (bus.wrap_mode[g]),
         .move_ready_o (bus.move_ready[g]),
         .obj_x_o      (bus.obj_x[g]),
         .obj_y_o      (bus.obj_y[g]),
         .edge_hit_o   (bus.edge_hit[g])
      );
   end

   // Commit strobe marks the cycle in which new positions first appear.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) commit_q <= 1'b0;
      else        commit_q <= frame;
   end

   assign commit = commit_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - directed and randomized checks of sprite_motion_ctrl against a reference model
module tb_sprite_motion_ctrl;
   import sprite_pkg::*;

   localparam int N     = 4;
   localparam int XMAX  = 640 - 68;
   localparam int YMAX  = 480 - 72;
   localparam int HOMEY = 300;

   logic clk_pix = 1'b0;
   logic rst_n   = 1'b1;
   logic frame   = 1'b0;
   logic commit;

   always #5 clk_pix = ~clk_pix;

   sprite_motion_ctrl_if #(.N_OBJ(N), .STEP_W(5)) bus ();

   sprite_motion_ctrl #(
      .N_OBJ(N), .OBJ_W(68), .OBJ_H(72), .STEP_W(5), .INIT_Y(HOMEY)
   ) dut (
      .clk_pix (clk_pix),
      .rst_n   (rst_n),
      .frame   (frame),
      .commit  (commit),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int mx [N];
   int my [N];
   int pdx[N];
   int pdy[N];
   bit pv [N];
   bit rdy[N];
   bit hit_e[N];
   bit commit_e;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int fold(input int v, input int maxv, input bit wrap, output bit hit);
      hit = 1'b1;
      if (v < 0)    return wrap ? v + maxv + 1 : 0;
      if (v > maxv) return wrap ? v - maxv - 1 : maxv;
      hit = 1'b0;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mx[i]    = (i * (640 / N) > XMAX) ? XMAX : i * (640 / N);
         my[i]    = HOMEY;
         pv[i]    = 1'b0;
         pdx[i]   = 0;
         pdy[i]   = 0;
         rdy[i]   = 1'b1;
         hit_e[i] = 1'b0;
      end
      commit_e = 1'b0;
   endtask

   // Applies one rising edge worth of behaviour to the model.
   task automatic model_step();
      for (int i = 0; i < N; i++) begin
         bit acc, hx, hy, wr;
         acc      = bus.move_valid[i] && (rdy[i] || frame);
         hit_e[i] = 1'b0;
`ifdef SPRITE_MOTION_WRAP_EN
         wr = bus.wrap_mode[i];
`else
         wr = 1'b0;
`endif
         if (frame && pv[i]) begin
            mx[i]    = fold(mx[i] + pdx[i], XMAX, wr, hx);
            my[i]    = fold(my[i] + pdy[i], YMAX, wr, hy);
            hit_e[i] = hx | hy;
         end
         if (acc) begin
            pv[i]  = 1'b1;
            pdx[i] = int'($signed(bus.move_dx[i]));
            pdy[i] = int'($signed(bus.move_dy[i]));
            rdy[i] = 1'b0;
         end else if (frame) begin
            pv[i]  = 1'b0;
            rdy[i] = 1'b1;
         end
      end
      commit_e = frame;
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         check($sformatf("obj_x[%0d]", i), int'(bus.obj_x[i]), mx[i]);
         check($sformatf("obj_y[%0d]", i), int'(bus.obj_y[i]), my[i]);
         check($sformatf("move_ready[%0d]", i), int'(bus.move_ready[i]), int'(rdy[i] | frame));
         check($sformatf("edge_hit[%0d]", i), int'(bus.edge_hit[i]), int'(hit_e[i]));
      end
      check("commit", int'(commit), int'(commit_e));
   endtask

   task automatic tick();
      @(posedge clk_pix);
      model_step();
      @(negedge clk_pix);
      check_all();
   endtask

   task automatic do_frame();
      frame = 1'b1;
      tick();
      frame = 1'b0;
   endtask

   task automatic issue(input int i, input int dx, input int dy);
      bus.move_valid[i] = 1'b1;
      bus.move_dx[i]    = 5'(dx);
      bus.move_dy[i]    = 5'(dy);
      tick();
      bus.move_valid[i] = 1'b0;
   endtask

   task automatic move_x_to(input int i, input int target);
      for (int k = 0; k < 80 && mx[i] != target; k++) begin
         int d;
         d = target - mx[i];
         if (d > 15)  d = 15;
         if (d < -16) d = -16;
         issue(i, d, 0);
         do_frame();
      end
      check($sformatf("move_x_to[%0d]", i), int'(bus.obj_x[i]), target);
   endtask

   initial begin
      bus.move_valid = '0;
      bus.move_dx    = '0;
      bus.move_dy    = '0;
      bus.wrap_mode  = '0;
      model_reset();

      // asynchronous reset with no clock edge involved
      #2 rst_n = 1'b0;
      #1 check_all();
      @(negedge clk_pix);
      rst_n = 1'b1;

      // basic step on obj0
      issue(0, 5, 0);
      do_frame();
      check("r031_x0", int'(bus.obj_x[0]), 5);
      check("r031_x1", int'(bus.obj_x[1]), 160);
      check("r031_commit", int'(commit), 1);

      // clamp at the right edge
      move_x_to(1, 570);
      issue(1, 10, 0);
      do_frame();
      check("r032_x1", int'(bus.obj_x[1]), XMAX);
      check("r032_hit", int'(bus.edge_hit[1]), 1);
      tick();
      check("r032_hit_clr", int'(bus.edge_hit[1]), 0);

      // zero step is a silent commit
      issue(1, 0, 0);
      do_frame();
      check("r023_x1", int'(bus.obj_x[1]), XMAX);
      check("r023_hit", int'(bus.edge_hit[1]), 0);

      // left edge: wrap when built in, clamp otherwise
      move_x_to(0, 2);
      bus.wrap_mode[0] = 1'b1;
      issue(0, -5, 0);
      do_frame();
`ifdef SPRITE_MOTION_WRAP_EN
      check("r033_x0", int'(bus.obj_x[0]), 570);
`else
      check("r033_x0", int'(bus.obj_x[0]), 0);
`endif
      check("r033_hit", int'(bus.edge_hit[0]), 1);
      bus.wrap_mode[0] = 1'b0;

      // second command in one frame is refused
      issue(2, 3, 0);
      check("r034_ready", int'(bus.move_ready[2]), 0);
      bus.move_valid[2] = 1'b1;
      bus.move_dx[2]    = 5'(7);
      tick();
      bus.move_valid[2] = 1'b0;
      do_frame();
      check("r034_x2", int'(bus.obj_x[2]), 323);

      // command coincident with frame queues behind the committing one
      issue(3, 4, 0);
      bus.move_valid[3] = 1'b1;
      bus.move_dx[3]    = 5'(-6);
      frame             = 1'b1;
      tick();
      frame             = 1'b0;
      bus.move_valid[3] = 1'b0;
      #1;
      check("r035_x3_first", int'(bus.obj_x[3]), 484);
      check("r035_ready", int'(bus.move_ready[3]), 0);
      @(negedge clk_pix);
      do_frame();
      check("r035_x3_second", int'(bus.obj_x[3]), 478);

      // reset discards a pending command
      issue(0, 3, 0);
      rst_n = 1'b0;
      model_reset();
      #1 check_all();
      check("r036_x0_reset", int'(bus.obj_x[0]), 0);
      @(negedge clk_pix);
      rst_n = 1'b1;
      do_frame();
      check("r036_x0_after", int'(bus.obj_x[0]), 0);
      check("r036_y0_after", int'(bus.obj_y[0]), HOMEY);

      // randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         bus.move_valid = 4'($urandom_range(0, 15));
         bus.wrap_mode  = 4'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) begin
            bus.move_dx[i] = 5'($urandom_range(0, 31));
            bus.move_dy[i] = 5'($urandom_range(0, 31));
         end
         frame = ($urandom_range(0, 4) == 0);
         tick();
      end
      frame          = 1'b0;
      bus.move_valid = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameter N_OBJ, default 4: number of independent object channels, legal range 1..8.
REQ-002 Parameter OBJ_W, default 68: scaled object width in pixels; X_MAX = H_RES-OBJ_W.
REQ-003 Parameter OBJ_H, default 72: scaled object height in pixels; Y_MAX = V_RES-OBJ_H.
REQ-004 Parameter STEP_W, default 5: width of signed per-frame step; legal steps -16..+15.
REQ-005 Parameter INIT_Y, default 300: reset y of every object.
REQ-006 clk_pix  input  1  pixel clock; the only clock.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 frame  input  1  one-cycle pulse at start of each frame, from the display timing block.
REQ-009 move_valid  input  N_OBJ  per-object move command valid.
REQ-010 move_ready  output  N_OBJ  per-object command slot free.
REQ-011 move_dx, move_dy  input  N_OBJ x STEP_W  signed per-object steps.
REQ-012 wrap_mode  input  N_OBJ  per-object edge mode: 1 = wrap, 0 = clamp.
REQ-013 obj_x, obj_y  output  N_OBJ x SCREEN_CORDW  committed object positions.
REQ-014 edge_hit  output  N_OBJ  one-cycle pulse when a commit was clamped or wrapped.
REQ-015 commit  output  1  one-cycle pulse in the cycle after each frame pulse.

Function
REQ-016 A command is accepted when move_valid[i] and move_ready[i] are both high on a rising clk_pix edge; dx/dy are stored in pending registers.
REQ-017 move_ready[i] drops the cycle after acceptance and stays low until the next frame pulse: one command per object per frame.
REQ-018 On frame, every object with a pending command computes new = old + step in signed SCREEN_CORDW+1 bits; obj_x/obj_y update at frame+1; objects with no pending command hold.
REQ-019 Clamp mode: result < 0 gives 0; result > X_MAX (Y_MAX) gives X_MAX (Y_MAX); edge_hit[i] pulses if either axis was corrected.
REQ-020 Wrap mode: result < 0 gives result+X_MAX+1; result > X_MAX gives result-(X_MAX+1); y likewise with Y_MAX; edge_hit[i] pulses.
REQ-021 Outputs change only at frame+1, never mid-frame: no tearing.
REQ-022 Command accepted in the same cycle as frame: the old pending is committed, the new command becomes pending for the next frame, and move_ready[i] is low at frame+1.
REQ-023 Zero step commits with no change and no edge_hit.
REQ-024 wrap_mode is sampled in the frame cycle.

Reset
REQ-025 On rst_n low, asynchronously: obj_x[i] = i*(H_RES/N_OBJ) clamped to X_MAX, obj_y[i] = INIT_Y, pending cleared, move_ready all 1, edge_hit 0, commit 0.
REQ-026 Reset mid-frame discards pending commands; the first frame pulse after release commits nothing.

Configuration
REQ-027 Macro SPRITE_MOTION_WRAP_EN defined: wrap behaviour per REQ-020 is built in.
REQ-028 Macro undefined: wrap logic is omitted, wrap_mode is ignored, and all objects clamp.

Structure
REQ-029 Package sprite_pkg holds H_RES=640, V_RES=480, SCREEN_CORDW=16, and typedefs coord_t (unsigned SCREEN_CORDW) and step_t (signed STEP_W).
REQ-030 Sub-module motion_channel implements one object (pending slot, adder, clamp/wrap); the top generates N_OBJ instances and ORs nothing across channels.

Verification
REQ-031 Reset, then obj0 dx=+5, dy=0, then frame -> obj_x[0]=5 at frame+1; other objects unchanged; commit pulses.
REQ-032 obj1 at x=570 (X_MAX=572), clamp, dx=+10, then frame -> obj_x[1]=572; edge_hit[1]=1 for one cycle.
REQ-033 With SPRITE_MOTION_WRAP_EN, obj0 x=2, wrap, dx=-5, then frame -> obj_x[0]=570; edge_hit[0]=1; without the macro -> 0.
REQ-034 Second valid on obj2 before frame -> not accepted (ready=0); after frame, only the first step is applied.
REQ-035 valid on obj3 coincident with frame while an older step is pending -> old step commits at frame+1, new step at the next frame.
REQ-036 rst_n asserted with obj0 pending dx=+3 -> positions return to reset values; the next frame produces no change.
